// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle HI/LO multiply/divide unit with MTHI/MTLO moves.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_MULT = c_CNT_W'(MULT_LAT);
  localparam logic [c_CNT_W-1:0] c_CNT_DIV  = c_CNT_W'(DIV_LAT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

  localparam logic [2:0] c_OP_MULT  = 3'd0;
  localparam logic [2:0] c_OP_MULTU = 3'd1;
  localparam logic [2:0] c_OP_DIV   = 3'd2;
  localparam logic [2:0] c_OP_DIVU  = 3'd3;
  localparam logic [2:0] c_OP_MTHI  = 3'd4;
  localparam logic [2:0] c_OP_MTLO  = 3'd5;

  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_pend_hi;
  logic [WIDTH-1:0]   r_pend_lo;

  logic               w_issue;
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;

  logic               w_div_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;
  logic [WIDTH-1:0]   w_div_hi;
  logic [WIDTH-1:0]   w_div_lo;

  assign w_issue = start & ~cancel & ~busy;

  // Operands are widened to 2*WIDTH (sign- or zero-extended) so one unsigned
  // multiplier yields the correct low 2*WIDTH bits for both MULT and MULTU.
  assign w_mul_a = op[0] ? {{WIDTH{1'b0}}, A} : {{WIDTH{A[WIDTH-1]}}, A};
  assign w_mul_b = op[0] ? {{WIDTH{1'b0}}, B} : {{WIDTH{B[WIDTH-1]}}, B};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed divide works on magnitudes; most-negative / -1 then falls out as
  // LO=A, HI=0 without overflowing the unsigned divider.
  assign w_div_signed = ~op[0];
  assign w_a_neg      = w_div_signed & A[WIDTH-1];
  assign w_b_neg      = w_div_signed & B[WIDTH-1];
  assign w_a_mag      = w_a_neg ? -A : A;
  assign w_b_mag      = w_b_neg ? -B : B;
  assign w_q_mag      = w_a_mag / w_b_mag;
  assign w_r_mag      = w_a_mag % w_b_mag;

  always_comb begin
    w_div_hi = w_a_neg ? -w_r_mag : w_r_mag;
    w_div_lo = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    if (B == '0) begin
      w_div_hi = A;
      w_div_lo = '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      r_cnt     <= c_CNT_ZERO;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else if (busy) begin
      if (r_cnt != c_CNT_ZERO) begin
        r_cnt <= r_cnt - c_CNT_ONE;
      end
      if (r_cnt == c_CNT_ONE) begin
        hi_out <= r_pend_hi;
        lo_out <= r_pend_lo;
        busy   <= 1'b0;
      end
    end else if (w_issue) begin
      case (op)
        c_OP_MULT, c_OP_MULTU: begin
          r_pend_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_pend_lo <= w_prod[WIDTH-1:0];
          r_cnt     <= c_CNT_MULT;
          busy      <= 1'b1;
        end
        c_OP_DIV, c_OP_DIVU: begin
          r_pend_hi <= w_div_hi;
          r_pend_lo <= w_div_lo;
          r_cnt     <= c_CNT_DIV;
          busy      <= 1'b1;
        end
        c_OP_MTHI: hi_out <= A;
        c_OP_MTLO: lo_out <= A;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench for muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int WIDTH    = 32;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cancel;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  muldiv_unit #(
    .WIDTH    (WIDTH),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cancel (cancel),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: architectural HI/LO plus the absolute cycle of commit.
  int          cyc = 0;
  logic        m_busy;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  int          m_commit_at;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (o)
      3'd0: res = sa * sb;
      3'd1: res = ua * ub;
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_hi   = '0;
    m_lo   = '0;
  endtask

  task automatic model_edge(input logic s, input logic c, input logic [2:0] o,
                            input logic [31:0] a, input logic [31:0] b);
    if (reset) model_reset();
    else if (m_busy) begin
      if (cyc == m_commit_at) begin
        {m_hi, m_lo} = m_pend;
        m_busy = 1'b0;
      end
    end else if (s && !c) begin
      case (o)
        3'd0, 3'd1: begin
          m_pend = ref_result(o, a, b);
          m_commit_at = cyc + MULT_LAT;
          m_busy = 1'b1;
        end
        3'd2, 3'd3: begin
          m_pend = ref_result(o, a, b);
          m_commit_at = cyc + DIV_LAT;
          m_busy = 1'b1;
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_busy"}, {63'd0, busy}, {63'd0, m_busy});
    chk({pfx, "_hi"}, {32'd0, hi_out}, {32'd0, m_hi});
    chk({pfx, "_lo"}, {32'd0, lo_out}, {32'd0, m_lo});
  endtask

  task automatic step(input logic s, input logic c, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] b);
    start  = s;
    cancel = c;
    op     = o;
    A      = a;
    B      = b;
    @(posedge clk);
    cyc++;
    model_edge(s, c, o, a, b);
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  // Issue an op and run until busy drops, returning the busy-high cycle count.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    busy_cycles = 0;
    step(1'b1, 1'b0, o, a, b);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      busy_cycles++;
      idle();
    end
  endtask

  task automatic pulse_reset();
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    cyc++;
    model_edge(start, cancel, op, A, B);
    #1;
    reset = 1'b0;
    check_outputs("rst_edge");
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 20));
    return $urandom;
  endfunction

  initial begin
    int bc;
    reset  = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 3'd0;
    A      = '0;
    B      = '0;
    model_reset();
    m_pend = '0;
    m_commit_at = 0;
    #2;
    check_outputs("reset_state");
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;

    // MULT / MULTU with a negative operand
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, bc);
    chk("mult_busy_cycles", 64'(bc), 64'd5);
    chk("mult_hi", {32'd0, hi_out}, 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", {32'd0, lo_out}, 64'h0000_0000_FFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, bc);
    chk("multu_hi", {32'd0, hi_out}, 64'h0000_0000_0000_0001);
    chk("multu_lo", {32'd0, lo_out}, 64'h0000_0000_FFFF_FFFE);

    // Signed divide, divide by zero, signed overflow
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, bc);
    chk("div_busy_cycles", 64'(bc), 64'd10);
    chk("div_lo", {32'd0, lo_out}, 64'h0000_0000_FFFF_FFFD);
    chk("div_hi", {32'd0, hi_out}, 64'h0000_0000_FFFF_FFFF);
    run_op(3'd3, 32'h0000_0007, 32'h0000_0000, bc);
    chk("divu0_busy_cycles", 64'(bc), 64'd10);
    chk("divu0_hi", {32'd0, hi_out}, 64'h0000_0000_0000_0007);
    chk("divu0_lo", {32'd0, lo_out}, 64'h0000_0000_FFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    chk("divovf_lo", {32'd0, lo_out}, 64'h0000_0000_8000_0000);
    chk("divovf_hi", {32'd0, hi_out}, 64'h0000_0000_0000_0000);

    // Starts while busy are dropped; MTLO when idle is immediate
    step(1'b1, 1'b0, 3'd1, 32'd3, 32'd4);
    step(1'b1, 1'b0, 3'd5, 32'h55, 32'd0);
    step(1'b1, 1'b0, 3'd3, 32'd100, 32'd7);
    for (int i = 0; i < 20 && busy; i++) idle();
    chk("busyign_hi", {32'd0, hi_out}, 64'd0);
    chk("busyign_lo", {32'd0, lo_out}, 64'd12);
    idle();
    chk("busyign_still_idle", {63'd0, busy}, 64'd0);
    step(1'b1, 1'b0, 3'd5, 32'h55, 32'd0);
    chk("mtlo_lo", {32'd0, lo_out}, 64'h55);
    chk("mtlo_busy", {63'd0, busy}, 64'd0);

    // Cancel kills only the same-cycle start
    step(1'b1, 1'b1, 3'd0, 32'd2, 32'd3);
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    chk("cancel_lo", {32'd0, lo_out}, 64'h55);
    step(1'b1, 1'b0, 3'd0, 32'd2, 32'd3);
    idle();
    step(1'b1, 1'b1, 3'd4, 32'hDEAD, 32'd0);
    for (int i = 0; i < 20 && busy; i++) idle();
    chk("cancel_inflight_lo", {32'd0, lo_out}, 64'd6);

    // No-op codes
    step(1'b1, 1'b0, 3'd6, 32'h1234, 32'd1);
    step(1'b1, 1'b0, 3'd7, 32'h1234, 32'd1);
    chk("noop_busy", {63'd0, busy}, 64'd0);

    // Reset aborts an in-flight divide
    step(1'b1, 1'b0, 3'd4, 32'h11, 32'd0);
    step(1'b1, 1'b0, 3'd5, 32'h22, 32'd0);
    step(1'b1, 1'b0, 3'd3, 32'd9, 32'd2);
    start = 1'b0;
    repeat (3) idle();
    pulse_reset();
    chk("rst_abort_hi", {32'd0, hi_out}, 64'd0);
    repeat (12) idle();
    chk("rst_abort_hi_late", {32'd0, hi_out}, 64'd0);
    chk("rst_abort_lo_late", {32'd0, lo_out}, 64'd0);

    // Back-to-back issue right out of reset-free idle
    step(1'b1, 1'b0, 3'd1, 32'd5, 32'd6);
    for (int i = 0; i < 20 && busy; i++) idle();
    step(1'b1, 1'b0, 3'd1, 32'd7, 32'd8);
    chk("b2b_busy", {63'd0, busy}, 64'd1);

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else step($urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d observed=running expected=finished", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
